// File: rtl/iir_out_fmt.sv
// Output formatter for the IIR filter: sfix22_En14 -> sfix16_En12 (round half-up, saturate),
// followed by a small FIFO toward a valid/ready consumer, with overflow and clip statistics.
module iir_out_fmt #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [21:0]                    in_data,
    input  logic                           in_valid,
    output logic [15:0]                    out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           ovf,
    output logic [CNT_W-1:0]               sat_cnt,
    input  logic                           clr_stats
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [20:0]   rnd;
    logic          pos_clip;
    logic          neg_clip;
    logic [15:0]   fmt_word;
    logic          fmt_sat;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic [LW-1:0] level_nxt;
    logic [15:0]   head_nxt;

    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    // Round half-up: drop two fraction bits, add back the first discarded bit.
    always_comb begin
        rnd      = {in_data[21], in_data[21:2]} + {20'd0, in_data[1]};
        pos_clip = ~rnd[20] & (|rnd[19:15]);
        neg_clip = rnd[20] & ~(&rnd[19:15]);
        fmt_sat  = pos_clip | neg_clip;
        if (pos_clip) begin
            fmt_word = 16'h7FFF;
        end else if (neg_clip) begin
            fmt_word = 16'h8000;
        end else begin
            fmt_word = rnd[15:0];
        end
    end

    assign full      = (level == LVL_FULL);
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & (~full | pop);
    assign drop      = in_valid & full & ~pop;

    // The incoming word becomes the head directly when nothing older survives this edge.
    always_comb begin
        level_nxt  = level;
        rd_ptr_nxt = rd_ptr;
        head_nxt   = out_data;
        if (push & ~pop) begin
            level_nxt = level + LVL_ONE;
        end else if (pop & ~push) begin
            level_nxt = level - LVL_ONE;
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + PTR_ONE;
        end
        if (push && ((level == '0) || (level == LVL_ONE && pop))) begin
            head_nxt = fmt_word;
        end else if (level_nxt != '0) begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fmt_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            out_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr   <= rd_ptr_nxt;
            level    <= level_nxt;
            out_data <= head_nxt;
        end
    end

    // Events take priority over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf     <= 1'b0;
            sat_cnt <= '0;
        end else begin
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_stats) begin
                ovf <= 1'b0;
            end
            if (push & fmt_sat) begin
                if (clr_stats) begin
                    sat_cnt <= CNT_ONE;
                end else if (sat_cnt != CNT_MAX) begin
                    sat_cnt <= sat_cnt + CNT_ONE;
                end
            end else if (clr_stats) begin
                sat_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/iir_out_fmt.md
# iir_out_fmt

- Output formatting and buffering stage placed directly after the final section adder of the IIR filter. It consumes the filter output (sfix22_En14, one sample per `in_valid` strobe) and produces an sfix16_En12 word.
- The conversion rounds half-up and saturates.
- A small FIFO decouples the non-stallable filter from a valid/ready downstream consumer.
- It reports overflow (dropped samples) and keeps a saturation event count.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries. Power of two, ≥2.
- `CNT_W`, default 16: width of the saturation event counter.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_data` in 22: filter output, sfix22_En14.
- `in_valid` in 1: sample strobe. There is no backpressure to the filter.
- `out_data` out 16: formatted sample, sfix16_En12 (FIFO head).
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts the head when `out_valid & out_ready`.
- `level` out clog2(DEPTH+1): current FIFO occupancy.
- `ovf` out 1: sticky flag, set when a sample is dropped.
- `sat_cnt` out CNT_W: saturating count of accepted samples that were clipped.
- `clr_stats` in 1: synchronous clear of `ovf` and `sat_cnt`.

## Operation

Format path (combinational, before the FIFO write):
- Rounding: r (21 bits) = sign-extend(in_data[21:2]) + in_data[1]. This is round-half-up, i.e. toward +inf on ties.
- Saturation: if r > 32767, word = 0x7FFF and sat = 1. If r < −32768, word = 0x8000 and sat = 1. Otherwise word = r[15:0] and sat = 0.

FIFO:
- Push condition: push = in_valid & (not full | pop), where pop = out_valid & out_ready.
- Push and pop in the same cycle while full are both performed. Level is unchanged, and the new word goes in behind the remaining entries.
- Push and pop in the same cycle while empty: pop is impossible (out_valid = 0), so only the push happens.
- Drop: in_valid & full & not pop → sample dropped, `ovf` ← 1, FIFO unchanged.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are derived from `level`.
- Ordering is strict FIFO. No sample is duplicated.

Statistics:
- `sat_cnt` increments when push & sat, and holds at 2^CNT_W−1.
- Dropped samples are never counted in `sat_cnt`.
- `clr_stats` zeroes `ovf` and `sat_cnt`.
- If a count or drop event occurs in the same cycle as `clr_stats`, the event wins: `sat_cnt` = 1 or `ovf` = 1 respectively.

Reset (`reset_n` low, asynchronous):
- Pointers, `level`, `out_valid`, `ovf` and `sat_cnt` go to 0. `out_data` goes to 0x0000.
- Contents of an in-flight FIFO are discarded.
- On release, operation starts on the next rising edge.

## Timing

- Latency: `in_valid` sampled at edge N into an empty FIFO → `out_valid` = 1 and `out_data` valid after edge N (visible in cycle N+1).
- `out_data` is the registered head entry. It is stable while `out_valid & !out_ready`.
- After a pop at edge M, the next entry is presented after edge M. Sustained throughput is 1 sample per cycle.
- `level`, `ovf` and `sat_cnt` are registered and update on the same edge as the causing event.
- Async reset assertion takes effect immediately. Deassertion is assumed synchronised externally.

## Test plan

- **Rounding:** 0x000006 → 0x0002. 0x3FFFFE → 0x0000. 0x01FFFC → 0x7FFF with sat_cnt unchanged.
- **Saturation:**
  - 0x01FFFE → 0x7FFF, sat_cnt = 1.
  - 0x1FFFFF → 0x7FFF, sat_cnt = 2.
  - 0x200000 → 0x8000, sat_cnt = 3.
- **Fill then drop:**
  - Setup: out_ready = 0, six consecutive strobes with values 1..6 in En12 units.
  - Required: level = 4, ovf rises on the 5th strobe, and after draining the outputs are 1,2,3,4.
- **Full with simultaneous push/pop:**
  - Setup: FIFO holds A,B,C,D; in_valid with E while out_ready = 1.
  - Required: level stays 4, ovf stays 0, and the output order is A,B,C,D,E.
- **Clear priority and counter ceiling:**
  - With CNT_W = 2: four saturating samples → sat_cnt = 3.
  - clr_stats together with a saturating push → sat_cnt = 1.
  - clr_stats alone → sat_cnt = 0, ovf = 0.
- **Reset mid-operation:**
  - Setup: level = 3, ovf = 1; pulse reset_n low between edges.
  - Required: all outputs go to 0 immediately. A new sample pushed after release appears first, and no stale data is seen.
